// File: rtl/fdse_arb_pkg.sv
// fdse_arb_pkg
// Shared definitions for the FDSE bank arbiter:
//   - arb_state_t : arbiter FSM encoding (ST_IDLE, ST_OWN)
//   - LOCK_CNT_W  : width of the lock ownership counter (covers MAX_LOCK up to 255)
//   - clog2()     : index width helper, never smaller than 1 bit
package fdse_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    localparam int LOCK_CNT_W = 8;

    // Width needed to hold an index in 0..value-1; at least one bit so that
    // a two-requester arbiter still gets a usable owner/pointer field.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/fdse_bank_arb_rr_pick.sv
// rr_pick
// Combinational round-robin priority encoder.
// Ports:
//   req   [NREQ-1:0] : request vector
//   ptr   [IW-1:0]   : index that has highest priority this cycle (0..NREQ-1)
//   valid            : at least one request present
//   idx   [IW-1:0]   : first requesting index at or after ptr, wrapping past NREQ-1 to 0
module rr_pick
    import fdse_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]        req,
    input  logic [clog2(NREQ)-1:0] ptr,
    output logic                   valid,
    output logic [clog2(NREQ)-1:0] idx
);

    localparam int IW = clog2(NREQ);

    int cand;

    // Scan from the farthest offset back toward ptr so the closest request
    // (smallest offset) is the last one written and therefore wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (req[IW'(cand)]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/fdse_bank_arb.sv
// fdse_bank_arb
// Round-robin arbiter/sequencer driving the shared CE, S and D pins of a bank
// of FDSE flip-flops, with a bounded exclusive lock for multi-cycle ownership.
// Ports:
//   C        : clock, rising edge
//   R        : synchronous active-high reset (drives reg_s=1 so the bank loads all ones)
//   req      : per-requester access request, level
//   set_req  : per-requester qualifier, 1 = set bank to all ones, 0 = write wdata
//   lock     : per-requester request to keep ownership after grant
//   wdata    : requester i data at [i*WIDTH +: WIDTH]
//   gnt      : one-hot grant pulse, one per served access
//   reg_ce   : bank clock enable
//   reg_s    : bank synchronous set
//   reg_d    : bank data
//   owner    : current/last granted index
//   locked   : arbiter is in the exclusive ownership state
//   lock_err : one-cycle pulse when ownership is forcibly released
// All outputs are registered; req sampled at one edge shows up on gnt/reg_*
// after the next edge.
module fdse_bank_arb
    import fdse_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_LOCK = 16
) (
    input  logic                     C,
    input  logic                     R,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          set_req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic                     reg_ce,
    output logic                     reg_s,
    output logic [WIDTH-1:0]         reg_d,
    output logic [clog2(NREQ)-1:0]   owner,
    output logic                     locked,
    output logic                     lock_err
);

    localparam int IW = clog2(NREQ);

    arb_state_t            state, state_nx;
    logic [IW-1:0]         rr_ptr, rr_ptr_nx;
    logic [LOCK_CNT_W-1:0] lock_cnt, lock_cnt_nx;
    logic [NREQ-1:0]       lock_block, lock_block_nx;

    logic [NREQ-1:0]       gnt_nx;
    logic                  reg_ce_nx;
    logic                  reg_s_nx;
    logic [WIDTH-1:0]      reg_d_nx;
    logic [IW-1:0]         owner_nx;
    logic                  lock_err_nx;

    logic                  pick_valid;
    logic [IW-1:0]         pick_idx;
    logic                  serve;
    logic [IW-1:0]         serve_idx;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State and output registers. Reset holds reg_s high on every reset
    // cycle so the FDSE bank captures its all-ones INIT value.
    always_ff @(posedge C) begin
        if (R) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            lock_cnt   <= '0;
            lock_block <= '0;
            gnt        <= '0;
            reg_ce     <= 1'b0;
            reg_s      <= 1'b1;
            reg_d      <= '0;
            owner      <= '0;
            locked     <= 1'b0;
            lock_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            rr_ptr     <= rr_ptr_nx;
            lock_cnt   <= lock_cnt_nx;
            lock_block <= lock_block_nx;
            gnt        <= gnt_nx;
            reg_ce     <= reg_ce_nx;
            reg_s      <= reg_s_nx;
            reg_d      <= reg_d_nx;
            owner      <= owner_nx;
            locked     <= (state_nx == ST_OWN);
            lock_err   <= lock_err_nx;
        end
    end

    // Next-state and next-output logic. A requester that was forcibly
    // released stays in lock_block until it is seen with lock low, so a
    // re-request with lock still held is served as a plain access.
    always_comb begin
        state_nx      = state;
        rr_ptr_nx     = rr_ptr;
        lock_cnt_nx   = lock_cnt;
        lock_block_nx = lock_block & lock;
        gnt_nx        = '0;
        reg_ce_nx     = 1'b0;
        reg_s_nx      = 1'b0;
        reg_d_nx      = reg_d;
        owner_nx      = owner;
        lock_err_nx   = 1'b0;
        serve         = 1'b0;
        serve_idx     = owner;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    serve     = 1'b1;
                    serve_idx = pick_idx;
                    owner_nx  = pick_idx;
                    rr_ptr_nx = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
                    if (lock[pick_idx] && !lock_block[pick_idx]) begin
                        state_nx    = ST_OWN;
                        lock_cnt_nx = '0;
                    end
                end
            end
            ST_OWN: begin
                if (!lock[owner]) begin
                    // The cycle lock falls is still served.
                    state_nx = ST_IDLE;
                    serve    = req[owner];
                end else if (lock_cnt == LOCK_CNT_W'(MAX_LOCK - 1)) begin
                    state_nx             = ST_IDLE;
                    lock_err_nx          = 1'b1;
                    lock_block_nx[owner] = 1'b1;
                end else begin
                    serve = req[owner];
                    if (lock_cnt != '1) begin
                        lock_cnt_nx = lock_cnt + LOCK_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Set takes precedence over write, mirroring S over CE in the FDSE.
        if (serve) begin
            gnt_nx[serve_idx] = 1'b1;
            if (set_req[serve_idx]) begin
                reg_s_nx = 1'b1;
                reg_d_nx = '0;
            end else begin
                reg_ce_nx = 1'b1;
                reg_d_nx  = wdata[int'(serve_idx) * WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_fdse_bank_arb.sv
// tb_fdse_bank_arb
// Drives two arbiter instances from the same inputs: dut_long (MAX_LOCK=16)
// and dut_short (MAX_LOCK=4). A behavioural model tracks ownership, pointer
// and blocking per instance and predicts every registered output.
module tb_fdse_bank_arb;
    import fdse_arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int OW    = clog2(NREQ);
    localparam int WD    = NREQ * WIDTH;
    localparam int ML0   = 16;
    localparam int ML1   = 4;

    logic            C = 1'b0;
    logic            R;
    logic [NREQ-1:0] req, set_req, lock;
    logic [WD-1:0]   wdata;

    logic [NREQ-1:0]  gnt_a [2];
    logic             ce_a  [2];
    logic             s_a   [2];
    logic [WIDTH-1:0] d_a   [2];
    logic [OW-1:0]    own_a [2];
    logic             lk_a  [2];
    logic             err_a [2];

    int n_checks = 0;
    int n_fail   = 0;

    bit               m_own   [2];
    int               m_owner [2];
    int               m_ptr   [2];
    int               m_held  [2];
    logic [NREQ-1:0]  m_block [2];
    logic [NREQ-1:0]  x_gnt   [2];
    logic             x_ce    [2];
    logic             x_s     [2];
    logic [WIDTH-1:0] x_d     [2];
    logic             x_err   [2];

    always #5 C = ~C;

    fdse_bank_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_LOCK(ML0)) dut_long (
        .C(C), .R(R), .req(req), .set_req(set_req), .lock(lock), .wdata(wdata),
        .gnt(gnt_a[0]), .reg_ce(ce_a[0]), .reg_s(s_a[0]), .reg_d(d_a[0]),
        .owner(own_a[0]), .locked(lk_a[0]), .lock_err(err_a[0])
    );

    fdse_bank_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_LOCK(ML1)) dut_short (
        .C(C), .R(R), .req(req), .set_req(set_req), .lock(lock), .wdata(wdata),
        .gnt(gnt_a[1]), .reg_ce(ce_a[1]), .reg_s(s_a[1]), .reg_d(d_a[1]),
        .owner(own_a[1]), .locked(lk_a[1]), .lock_err(err_a[1])
    );

    // Reference model: one call per clock edge using the inputs seen at that edge.
    task automatic model_step(input int k);
        logic [NREQ-1:0] nb;
        int served;
        int maxl;
        maxl = (k == 0) ? ML0 : ML1;
        if (R) begin
            m_own[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; m_held[k] = 0; m_block[k] = '0;
            x_gnt[k] = '0; x_ce[k] = 1'b0; x_s[k] = 1'b1; x_d[k] = '0; x_err[k] = 1'b0;
        end else begin
            served   = -1;
            x_err[k] = 1'b0;
            nb       = m_block[k] & lock;
            if (!m_own[k]) begin
                for (int off = 0; off < NREQ; off++) begin
                    int i;
                    i = (m_ptr[k] + off) % NREQ;
                    if (served < 0 && req[i]) served = i;
                end
                if (served >= 0) begin
                    m_owner[k] = served;
                    m_ptr[k]   = (served + 1) % NREQ;
                    if (lock[served] && !m_block[k][served]) begin
                        m_own[k]  = 1;
                        m_held[k] = 0;
                    end
                end
            end else begin
                m_held[k] = m_held[k] + 1;
                if (!lock[m_owner[k]]) begin
                    m_own[k] = 0;
                    if (req[m_owner[k]]) served = m_owner[k];
                end else if (m_held[k] >= maxl) begin
                    m_own[k]          = 0;
                    x_err[k]          = 1'b1;
                    nb[m_owner[k]]    = 1'b1;
                end else if (req[m_owner[k]]) begin
                    served = m_owner[k];
                end
            end
            m_block[k] = nb;
            x_gnt[k]   = '0;
            x_ce[k]    = 1'b0;
            x_s[k]     = 1'b0;
            if (served >= 0) begin
                x_gnt[k][served] = 1'b1;
                if (set_req[served]) begin
                    x_s[k] = 1'b1;
                    x_d[k] = '0;
                end else begin
                    x_ce[k] = 1'b1;
                    x_d[k]  = wdata[served * WIDTH +: WIDTH];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge C);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic test_reset();
        R = 1'b1; req = '0; set_req = '0; lock = '0; wdata = WD'($urandom);
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({gnt_a[k], ce_a[k], s_a[k], d_a[k], own_a[k], lk_a[k], err_a[k]} !==
                    {4'b0000, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("[TB] FAIL reset_state inst%0d cyc%0d: got gnt=%b ce=%b s=%b d=%h own=%0d lk=%b err=%b, expected s=1 all else 0",
                             k, c, gnt_a[k], ce_a[k], s_a[k], d_a[k], own_a[k], lk_a[k], err_a[k]);
                end
            end
        end
        R = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({s_a[k], ce_a[k], gnt_a[k]} !== 6'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_release inst%0d: got s=%b ce=%b gnt=%b, expected all 0", k, s_a[k], ce_a[k], gnt_a[k]);
            end
        end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'b1111; set_req = '0; lock = '0; wdata = WD'($urandom);
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({gnt_a[k], ce_a[k], s_a[k], d_a[k]} !== {exp_seq[c], 1'b1, 1'b0, wdata[(c % NREQ) * WIDTH +: WIDTH]}) begin
                    n_fail++;
                    $display("[TB] FAIL fairness inst%0d cyc%0d: got gnt=%b ce=%b s=%b d=%h, expected gnt=%b ce=1 s=0 d=%h",
                             k, c, gnt_a[k], ce_a[k], s_a[k], d_a[k], exp_seq[c], wdata[(c % NREQ) * WIDTH +: WIDTH]);
                end
            end
        end
    endtask

    task automatic test_set_priority();
        req = 4'b0100; set_req = 4'b0100; lock = '0;
        wdata = WD'($urandom);
        wdata[2 * WIDTH +: WIDTH] = 8'h3C;
        tick();
        n_checks++;
        if ({gnt_a[0], s_a[0], ce_a[0], d_a[0]} !== {4'b0100, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("[TB] FAIL set_priority: got gnt=%b s=%b ce=%b d=%h, expected gnt=0100 s=1 ce=0 d=00", gnt_a[0], s_a[0], ce_a[0], d_a[0]);
        end
        req = 4'b0001; set_req = '0;
        wdata[0 +: WIDTH] = 8'hA5;
        tick();
        n_checks++;
        if ({gnt_a[0], s_a[0], ce_a[0], d_a[0]} !== {4'b0001, 1'b0, 1'b1, 8'hA5}) begin
            n_fail++;
            $display("[TB] FAIL write_after_set: got gnt=%b s=%b ce=%b d=%h, expected gnt=0001 s=0 ce=1 d=a5", gnt_a[0], s_a[0], ce_a[0], d_a[0]);
        end
        req = '0;
        wdata = WD'($urandom);
        tick();
        n_checks++;
        if ({gnt_a[0], s_a[0], ce_a[0], d_a[0]} !== {4'b0000, 1'b0, 1'b0, 8'hA5}) begin
            n_fail++;
            $display("[TB] FAIL idle_hold: got gnt=%b s=%b ce=%b d=%h, expected gnt=0000 s=0 ce=0 d=a5", gnt_a[0], s_a[0], ce_a[0], d_a[0]);
        end
    endtask

    task automatic test_wrap();
        logic [NREQ-1:0] exp_seq [3];
        exp_seq = '{4'b0100, 4'b1000, 4'b0001};
        set_req = '0; lock = '0;
        for (int c = 0; c < 3; c++) begin
            req = (c == 0) ? 4'b0100 : 4'b1001;
            if (c == 2) req = 4'b0001;
            tick();
            n_checks++;
            if (gnt_a[0] !== exp_seq[c]) begin
                n_fail++;
                $display("[TB] FAIL wrap cyc%0d: got gnt=%b, expected %b", c, gnt_a[0], exp_seq[c]);
            end
        end
    endtask

    task automatic test_lock();
        R = 1'b1; req = '0; set_req = '0; lock = '0;
        tick();
        R = 1'b0; req = 4'b0001;
        tick();
        req = 4'b1011; lock = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({gnt_a[0], lk_a[0], own_a[0]} !== {4'b0010, 1'b1, 2'd1}) begin
                n_fail++;
                $display("[TB] FAIL lock_hold cyc%0d: got gnt=%b locked=%b owner=%0d, expected gnt=0010 locked=1 owner=1", c, gnt_a[0], lk_a[0], own_a[0]);
            end
            n_checks++;
            if ({gnt_a[1], lk_a[1], err_a[1]} !== {x_gnt[1], m_own[1], x_err[1]}) begin
                n_fail++;
                $display("[TB] FAIL lock_short cyc%0d: got gnt=%b locked=%b err=%b, expected gnt=%b locked=%b err=%b",
                         c, gnt_a[1], lk_a[1], err_a[1], x_gnt[1], m_own[1], x_err[1]);
            end
        end
        req = 4'b1001; lock = '0;
        tick();
        n_checks++;
        if ({gnt_a[0], lk_a[0]} !== {4'b0000, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL lock_release: got gnt=%b locked=%b, expected gnt=0000 locked=0", gnt_a[0], lk_a[0]);
        end
        tick();
        n_checks++;
        if (gnt_a[0] !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL lock_after_3: got gnt=%b, expected 1000", gnt_a[0]);
        end
        tick();
        n_checks++;
        if (gnt_a[0] !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL lock_after_0: got gnt=%b, expected 0001", gnt_a[0]);
        end
    endtask

    task automatic test_timeout();
        R = 1'b1; req = '0; set_req = '0; lock = '0;
        tick();
        R = 1'b0; req = 4'b0101; lock = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if ({gnt_a[1], lk_a[1], err_a[1]} !== {4'b0001, 1'b1, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL timeout_grant cyc%0d: got gnt=%b locked=%b err=%b, expected gnt=0001 locked=1 err=0", c, gnt_a[1], lk_a[1], err_a[1]);
            end
        end
        tick();
        n_checks++;
        if ({gnt_a[1], lk_a[1], err_a[1]} !== {4'b0000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL timeout_err: got gnt=%b locked=%b err=%b, expected gnt=0000 locked=0 err=1", gnt_a[1], lk_a[1], err_a[1]);
        end
        tick();
        n_checks++;
        if ({gnt_a[1], lk_a[1], err_a[1]} !== {4'b0100, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL timeout_next: got gnt=%b locked=%b err=%b, expected gnt=0100 locked=0 err=0", gnt_a[1], lk_a[1], err_a[1]);
        end
        tick();
        n_checks++;
        if ({gnt_a[1], lk_a[1]} !== {4'b0001, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL timeout_blocked: got gnt=%b locked=%b, expected gnt=0001 locked=0", gnt_a[1], lk_a[1]);
        end
        req = '0; lock = '0;
        tick();
        req = 4'b0001; lock = 4'b0001;
        tick();
        n_checks++;
        if ({gnt_a[1], lk_a[1]} !== {4'b0001, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL timeout_relock: got gnt=%b locked=%b, expected gnt=0001 locked=1", gnt_a[1], lk_a[1]);
        end
    endtask

    task automatic test_reset_mid_own();
        R = 1'b1; req = '0; set_req = '0; lock = '0;
        tick();
        R = 1'b0; req = 4'b0010; lock = 4'b0010;
        tick();
        tick();
        n_checks++;
        if (lk_a[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_own_setup: got locked=%b, expected 1", lk_a[0]);
        end
        R = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({lk_a[k], gnt_a[k], s_a[k]} !== {1'b0, 4'b0000, 1'b1}) begin
                    n_fail++;
                    $display("[TB] FAIL mid_own_reset inst%0d cyc%0d: got locked=%b gnt=%b s=%b, expected locked=0 gnt=0000 s=1",
                             k, c, lk_a[k], gnt_a[k], s_a[k]);
                end
            end
        end
        R = 1'b0; req = 4'b1010; lock = '0;
        tick();
        n_checks++;
        if (gnt_a[0] !== 4'b0010) begin
            n_fail++;
            $display("[TB] FAIL mid_own_ptr: got gnt=%b, expected 0010", gnt_a[0]);
        end
    endtask

    task automatic test_random();
        lock = '0;
        for (int c = 0; c < 600; c++) begin
            R       = ($urandom_range(0, 79) == 0);
            req     = NREQ'($urandom);
            set_req = NREQ'($urandom & $urandom);
            wdata   = WD'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 5) == 0) lock[i] = ~lock[i];
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({gnt_a[k], ce_a[k], s_a[k], d_a[k], own_a[k], lk_a[k], err_a[k]} !==
                    {x_gnt[k], x_ce[k], x_s[k], x_d[k], OW'(m_owner[k]), m_own[k], x_err[k]}) begin
                    n_fail++;
                    $display("[TB] FAIL random inst%0d cyc%0d: got gnt=%b ce=%b s=%b d=%h own=%0d lk=%b err=%b, expected gnt=%b ce=%b s=%b d=%h own=%0d lk=%b err=%b",
                             k, c, gnt_a[k], ce_a[k], s_a[k], d_a[k], own_a[k], lk_a[k], err_a[k],
                             x_gnt[k], x_ce[k], x_s[k], x_d[k], m_owner[k], m_own[k], x_err[k]);
                end
            end
        end
    endtask

    initial begin
        R = 1'b1; req = '0; set_req = '0; lock = '0; wdata = '0;
        test_reset();
        test_fairness();
        test_set_priority();
        test_wrap();
        test_lock();
        test_timeout();
        test_reset_mid_own();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
